// File: rtl/gated_or_filter.sv
`default_nettype none
// ============================================================================
// Module   : gated_or_filter
// Purpose  : Multi-lane gated-OR (C & (A | B)) with per-lane stability
//            filter, saturating rising-edge counter and sticky rise flags.
// Revision : 1.0 - initial release
// ============================================================================
module gated_or_filter #(
    parameter int WIDTH  = 4,
    parameter int STABLE = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic             any_d,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [WIDTH-1:0] sticky
);

    localparam int              c_CW       = $clog2(STABLE + 1);
    localparam int              c_SW       = CNT_W + 6;
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(STABLE - 1);
    localparam logic [c_SW-1:0] c_CNT_MAX  = c_SW'((1 << CNT_W) - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [c_CW-1:0]  cnt_q [WIDTH];
    logic [c_CW-1:0]  cnt_d [WIDTH];
    logic [CNT_W-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] sticky_q, sticky_d;

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_rise;
    logic [c_SW-1:0]  w_pop;
    logic [c_SW-1:0]  w_base;
    logic [c_SW-1:0]  w_sum;

    assign w_raw = C & (A | B);

    // Per-lane filter: a lane flips only on the STABLE-th consecutive
    // enabled cycle in which the raw term disagrees with the output.
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (en) begin
                if (w_raw[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == c_LAST) begin
                    out_d[i] = w_raw[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = out_d & ~out_q;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + c_SW'(w_rise[i]);
        end
    end

    // Clear restarts from zero but still records rises on the same edge.
    assign w_base   = clr ? '0 : c_SW'(edge_q);
    assign w_sum    = w_base + w_pop;
    assign edge_d   = (w_sum > c_CNT_MAX) ? '1 : w_sum[CNT_W-1:0];
    assign sticky_d = clr ? w_rise : (sticky_q | w_rise);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= '0;
            edge_q   <= '0;
            sticky_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q    <= out_d;
            edge_q   <= edge_d;
            sticky_q <= sticky_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign D        = out_q;
    assign any_d    = |out_q;
    assign edge_cnt = edge_q;
    assign sticky   = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_gated_or_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gated_or_filter
// Purpose  : Self-checking bench: vector table, directed corner sequences
//            and randomized traffic against a sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gated_or_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] a, b, c;

    logic [3:0] d_m, st_m;
    logic       any_m;
    logic [7:0] cnt_m;
    logic [3:0] d_s, st_s;
    logic       any_s;
    logic [1:0] cnt_s;

    always #5 clk = ~clk;

    gated_or_filter #(.WIDTH(4), .STABLE(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .A(a), .B(b), .C(c),
        .D(d_m), .any_d(any_m), .edge_cnt(cnt_m), .sticky(st_m)
    );

    gated_or_filter #(.WIDTH(4), .STABLE(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .A(a), .B(b), .C(c),
        .D(d_s), .any_d(any_s), .edge_cnt(cnt_s), .sticky(st_s)
    );

    int checks   = 0;
    int failures = 0;

    // Model: index 0 = main instance, 1 = saturation instance.
    int       m_stable [2] = '{3, 1};
    int       m_max    [2] = '{255, 3};
    bit [3:0] m_d      [2];
    int       m_cnt    [2];
    bit [3:0] m_st     [2];
    bit       hist     [2][4][$];

    typedef struct {
        bit       r;
        bit       e;
        bit       cl;
        bit [3:0] a;
        bit [3:0] b;
        bit [3:0] c;
        bit [3:0] d;
        int       cnt;
        bit [3:0] st;
    } vec_t;

    vec_t tbl[$];
    int   sat_exp[5] = '{1, 2, 3, 3, 3};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_d[m]   = '0;
            m_cnt[m] = 0;
            m_st[m]  = '0;
            for (int l = 0; l < 4; l++) hist[m][l].delete();
        end
    endtask

    // A lane flips once its most recent STABLE enabled samples, all taken
    // since its last change, disagree with its current value.
    task automatic model_edge();
        bit [3:0] raw;
        bit [3:0] rise;
        bit       all_diff;
        int       total;
        raw = c & (a | b);
        for (int m = 0; m < 2; m++) begin
            rise = '0;
            if (en) begin
                for (int l = 0; l < 4; l++) begin
                    hist[m][l].push_back(raw[l]);
                    if (hist[m][l].size() > m_stable[m]) void'(hist[m][l].pop_front());
                    if (hist[m][l].size() == m_stable[m]) begin
                        all_diff = 1'b1;
                        for (int j = 0; j < m_stable[m]; j++)
                            if (hist[m][l][j] == m_d[m][l]) all_diff = 1'b0;
                        if (all_diff) begin
                            m_d[m][l] = raw[l];
                            rise[l]   = raw[l];
                            hist[m][l].delete();
                        end
                    end
                end
            end
            total    = (clr ? 0 : m_cnt[m]) + $countones(rise);
            m_cnt[m] = (total > m_max[m]) ? m_max[m] : total;
            m_st[m]  = clr ? rise : (m_st[m] | rise);
        end
    endtask

    task automatic check_model();
        chk("D_main",      int'(d_m),   int'(m_d[0]));
        chk("any_main",    int'(any_m), int'(|m_d[0]));
        chk("cnt_main",    int'(cnt_m), m_cnt[0]);
        chk("sticky_main", int'(st_m),  int'(m_st[0]));
        chk("D_sat",       int'(d_s),   int'(m_d[1]));
        chk("any_sat",     int'(any_s), int'(|m_d[1]));
        chk("cnt_sat",     int'(cnt_s), m_cnt[1]);
        chk("sticky_sat",  int'(st_s),  int'(m_st[1]));
    endtask

    task automatic tick(input bit e, input bit cl, input bit [3:0] aa,
                        input bit [3:0] bb, input bit [3:0] cc);
        en  = e;
        clr = cl;
        a   = aa;
        b   = bb;
        c   = cc;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic addv(input bit r, input bit e, input bit cl,
                        input bit [3:0] aa, input bit [3:0] bb, input bit [3:0] cc,
                        input bit [3:0] dd, input int cn, input bit [3:0] ss);
        vec_t v;
        v.r = r; v.e = e; v.cl = cl; v.a = aa; v.b = bb; v.c = cc;
        v.d = dd; v.cnt = cn; v.st = ss;
        tbl.push_back(v);
    endtask

    task automatic check_main(input string nm, input bit [3:0] dd,
                              input int cn, input bit [3:0] ss);
        chk({nm, "_D"},      int'(d_m),   int'(dd));
        chk({nm, "_any"},    int'(any_m), int'(|dd));
        chk({nm, "_cnt"},    int'(cnt_m), cn);
        chk({nm, "_sticky"}, int'(st_m),  int'(ss));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; a = '0; b = '0; c = '0;
        model_reset();
        #1;
        check_main("reset", 4'h0, 0, 4'h0);
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic follow
        addv(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0);
        for (int i = 0; i < 2; i++) addv(0, 1, 0, 4'h5, 4'h0, 4'hF, 4'h0, 0, 4'h0);
        addv(0, 1, 0, 4'h5, 4'h0, 4'hF, 4'h5, 2, 4'h5);
        // glitch reject
        addv(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0);
        for (int i = 0; i < 2; i++) addv(0, 1, 0, 4'h1, 4'h0, 4'hF, 4'h0, 0, 4'h0);
        for (int i = 0; i < 2; i++) addv(0, 1, 0, 4'h0, 4'h0, 4'hF, 4'h0, 0, 4'h0);
        for (int i = 0; i < 2; i++) addv(0, 1, 0, 4'h0, 4'h8, 4'h8, 4'h0, 0, 4'h0);
        addv(0, 1, 0, 4'h0, 4'h8, 4'h8, 4'h8, 1, 4'h8);
        // enable hold: inputs change while disabled and must be ignored
        for (int i = 0; i < 2; i++) addv(0, 1, 0, 4'h2, 4'h8, 4'hF, 4'h8, 1, 4'h8);
        for (int i = 0; i < 5; i++) addv(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h8, 1, 4'h8);
        addv(0, 1, 0, 4'h2, 4'h8, 4'hF, 4'hA, 2, 4'hA);
        // fall and re-rise on lane 2
        for (int i = 0; i < 2; i++) addv(0, 1, 0, 4'h6, 4'h8, 4'hF, 4'hA, 2, 4'hA);
        addv(0, 1, 0, 4'h6, 4'h8, 4'hF, 4'hE, 3, 4'hE);
        for (int i = 0; i < 2; i++) addv(0, 1, 0, 4'h6, 4'h8, 4'hB, 4'hE, 3, 4'hE);
        addv(0, 1, 0, 4'h6, 4'h8, 4'hB, 4'hA, 3, 4'hE);
        for (int i = 0; i < 2; i++) addv(0, 1, 0, 4'h6, 4'h8, 4'hF, 4'hA, 3, 4'hE);
        addv(0, 1, 0, 4'h6, 4'h8, 4'hF, 4'hE, 4, 4'hE);

        foreach (tbl[i]) begin
            if (tbl[i].r) do_reset();
            else tick(tbl[i].e, tbl[i].cl, tbl[i].a, tbl[i].b, tbl[i].c);
            check_main($sformatf("tbl%0d", i), tbl[i].d, tbl[i].cnt, tbl[i].st);
        end

        // saturation on the STABLE=1, CNT_W=2 instance
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0, (k % 2 == 0) ? 4'h1 : 4'h0, 4'h0, 4'hF);
            if (k % 2 == 0) chk($sformatf("sat_rise%0d", k / 2), int'(cnt_s), sat_exp[k / 2]);
        end

        // clear collision: five lane-0 rises, then clr on the lane-2 rise edge
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 4'h1, 4'h0, 4'hF);
            for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 4'h0, 4'h0, 4'hF);
        end
        check_main("pre_clr", 4'h0, 5, 4'h1);
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 4'h4, 4'h0, 4'hF);
        tick(1'b1, 1'b1, 4'h4, 4'h0, 4'hF);
        check_main("clr_collide", 4'h4, 1, 4'h4);

        // reset mid-count on lane 3 discards the partial count
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 4'h8, 4'h0, 4'h8);
        do_reset();
        check_main("mid_rst", 4'h0, 0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 4'h8, 4'h0, 4'h8);
            check_main($sformatf("post_rst%0d", i), 4'h0, 0, 4'h0);
        end
        tick(1'b1, 1'b0, 4'h8, 4'h0, 4'h8);
        check_main("post_rst2", 4'h8, 1, 4'h8);

        // randomized traffic with slowly changing inputs so lanes settle
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(149) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(9) != 0, $urandom_range(19) == 0,
                     ($urandom_range(3) == 0) ? 4'($urandom) : a,
                     ($urandom_range(3) == 0) ? 4'($urandom) : b,
                     ($urandom_range(3) == 0) ? 4'($urandom) : c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gated_or_filter.md
# gated_or_filter

Multi-lane, registered successor to the single-bit gated-OR function D = C & (A | B). Each of WIDTH lanes computes the gated-OR term. A per-lane stability filter only passes a change to the output after it has persisted for STABLE consecutive enabled cycles. The block also keeps a saturating count of output rising edges and a per-lane sticky flag, so control logic can poll for events instead of watching raw levels.

## Interface
- WIDTH, 4: number of independent lanes (1..32).
- STABLE, 3: consecutive enabled cycles a differing raw value must persist before D follows it (1..255).
- CNT_W, 8: width of edge_cnt (1..16).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enable: filter advances only when 1.
- clr  in  1  synchronous clear of edge_cnt and sticky; not gated by en.
- A  in  WIDTH  per-lane OR input.
- B  in  WIDTH  per-lane OR input.
- C  in  WIDTH  per-lane gate input.
- D  out  WIDTH  filtered, registered gated-OR result.
- any_d  out  1  OR-reduction of D.
- edge_cnt  out  CNT_W  saturating count of D rising edges.
- sticky  out  WIDTH  per-lane latched "D rose" flag.

## Operation
- Raw term, combinational: raw[i] = C[i] & (A[i] | B[i]).
- Per-lane filter counter cnt[i], width clog2(STABLE+1); not visible at the ports.
- When en=1 and raw[i]==D[i]: cnt[i] <= 0.
- When en=1, raw[i]!=D[i] and cnt[i] < STABLE-1: cnt[i] <= cnt[i]+1.
- When en=1, raw[i]!=D[i] and cnt[i]==STABLE-1: D[i] <= raw[i] and cnt[i] <= 0.
- When en=0: D and cnt hold. Inputs are ignored.
- STABLE=1: D is raw registered once, with no filtering.
- rise[i]: asserted on an edge where D[i] goes 0->1. Only 0->1 transitions count; falling edges affect D only.
- edge_cnt, with clr=0: edge_cnt <= min(edge_cnt + popcount(rise), 2^CNT_W - 1). Addition is at CNT_W+6 bits, then clamped. Once saturated, it holds until clr or rst.
- sticky, with clr=0: sticky <= sticky | rise.
- clr=1: edge_cnt <= popcount(rise), clamped, and sticky <= rise. Rises on the clearing edge are never lost.
- any_d = |D. Driven combinationally from the D register, so it carries no extra latency.
- Lanes are fully independent. Simultaneous rises in several lanes are all counted on the same edge.

## Timing
- Reset, asynchronous and immediate: D=0, cnt=0, edge_cnt=0, sticky=0, any_d=0.
- The first edge after rst deasserts behaves as a normal cycle.
- Reset asserted mid-count discards the partial count; a new change needs a full STABLE cycles again.
- Latency: with raw[i] steady and different from D[i], and en=1 continuously, D[i] updates on the STABLE-th rising edge. The first edge counted is the first at which the difference is sampled.
- A raw pulse shorter than STABLE enabled cycles never reaches D.
- en=0 cycles stretch latency one-for-one. The pending count is preserved, not reset.
- A raw value that returns to D[i] before completing resets the count, even on the STABLE-1 edge.
- edge_cnt and sticky update on the same edge as the D rise they record.
- No combinational path from A, B, C, en or clr to any output.

## Test plan
- Basic follow: WIDTH=4, STABLE=3, en=1, C=4'b1111, A=4'b0101, B=0 held. Required: D=0 after edges 1 and 2, D=4'b0101 after edge 3, edge_cnt=2, sticky=4'b0101, any_d=1.
- Glitch reject: from D=0, hold raw lane0=1 for 2 edges, then A=0. Required: D stays 0 throughout and edge_cnt stays 0. Then hold B[3]=1, C[3]=1 for 3 edges. Required: D=4'b1000 and edge_cnt=1.
- Enable hold: raw lane1 high with en=1 for 2 edges, en=0 for 5 edges, then en=1 for 1 edge. Required: D[1] rises only on that final edge; D is unchanged during the en=0 cycles.
- Fall and re-rise: lane2 up (edge_cnt=1), then C[2]=0 for 3 edges. Required: D[2]=0 and edge_cnt=1. Then C[2]=1 for 3 edges. Required: D[2]=1, edge_cnt=2, sticky[2]=1.
- Saturation: CNT_W=2, STABLE=1. Toggle lane0 raw to produce 5 rises. Required: edge_cnt=1, 2, 3, 3, 3.
- Clear collision and reset: with sticky=4'b0001 and edge_cnt=5, assert clr on the edge where D[2] rises. Required: edge_cnt=1, sticky=4'b0100. Then pulse rst mid-count on lane3. Required: all outputs 0 immediately, and lane3 needs 3 fresh edges to rise.
